pc_sequencer: RTL

//  Control sequencer for the next-address mux: decodes control-transfer strobes into the 3-bit
//  pc_select code, owns the call/return stack that feeds the mux STACK input, and tracks

---
 rtl/pc_sequencer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Next-address mux control: decodes control-transfer strobes into pc_select,
// owns the call/return stack, and tracks halt, flush and stack-fault state.
module pc_sequencer #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     is_branch,
    input  logic                     branch_taken,
    input  logic                     is_jpc,
    input  logic                     is_jr,
    input  logic                     is_call,
    input  logic                     is_ret,
    input  logic                     halt_req,
    input  logic                     resume,
    input  logic [ADDR_W-1:0]        pc_1,
    output logic [2:0]               pc_select,
    output logic [ADDR_W-1:0]        stack_top,
    output logic [$clog2(DEPTH):0]   stack_depth,
    output logic                     flush,
    output logic                     halted,
    output logic                     stack_overflow,
    output logic                     stack_underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;
    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

    localparam logic [2:0] SEL_STACK  = 3'b000;
    localparam logic [2:0] SEL_JR     = 3'b001;
    localparam logic [2:0] SEL_NPC    = 3'b010;
    localparam logic [2:0] SEL_BRANCH = 3'b011;
    localparam logic [2:0] SEL_HALT   = 3'b100;
    localparam logic [2:0] SEL_JPC    = 3'b101;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_HALTED,
        ST_FAULT
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [ADDR_W-1:0]   entries [DEPTH];
    logic [DW-1:0]       depth;
    logic [DW-1:0]       top_index;
    logic                stack_empty;
    logic                stack_full;
    logic                do_push;
    logic                do_pop;
    logic                set_overflow;
    logic                set_underflow;

    assign stack_empty = (depth == '0);
    assign stack_full  = (depth == DEPTH_MAX);
    assign top_index   = depth - DW'(1);
    assign stack_top   = stack_empty ? '0 : entries[top_index[AW-1:0]];
    assign stack_depth = depth;
    assign halted      = reset && (state == ST_HALTED);

    // Strobe decode in fixed priority order; a blocked push/pop faults instead of wrapping.
    always_comb begin
        next_state    = state;
        pc_select     = SEL_NPC;
        flush         = 1'b0;
        do_push       = 1'b0;
        do_pop        = 1'b0;
        set_overflow  = 1'b0;
        set_underflow = 1'b0;

        unique case (state)
            ST_RUN: begin
                if (stall) begin
                    pc_select = SEL_HALT;
                end else if (halt_req) begin
                    pc_select  = SEL_HALT;
                    next_state = ST_HALTED;
                end else if (is_ret && stack_empty) begin
                    pc_select     = SEL_HALT;
                    set_underflow = 1'b1;
                    next_state    = ST_FAULT;
                end else if (is_ret) begin
                    pc_select  = SEL_STACK;
                    do_pop     = 1'b1;
                    next_state = ST_FLUSH;
                end else if (is_call && stack_full) begin
                    pc_select    = SEL_HALT;
                    set_overflow = 1'b1;
                    next_state   = ST_FAULT;
                end else if (is_call) begin
                    pc_select  = SEL_JPC;
                    do_push    = 1'b1;
                    next_state = ST_FLUSH;
                end else if (is_jpc) begin
                    pc_select  = SEL_JPC;
                    next_state = ST_FLUSH;
                end else if (is_jr) begin
                    pc_select  = SEL_JR;
                    next_state = ST_FLUSH;
                end else if (is_branch && branch_taken) begin
                    pc_select  = SEL_BRANCH;
                    next_state = ST_FLUSH;
                end else begin
                    pc_select = SEL_NPC;
                end
            end
            ST_FLUSH: begin
                flush = 1'b1;
                if (stall) begin
                    pc_select = SEL_HALT;
                end else begin
                    pc_select  = SEL_NPC;
                    next_state = ST_RUN;
                end
            end
            ST_HALTED: begin
                if (resume) begin
                    pc_select  = SEL_NPC;
                    next_state = ST_RUN;
                end else begin
                    pc_select = SEL_HALT;
                end
            end
            ST_FAULT: begin
                pc_select = SEL_HALT;
            end
            default: begin
                pc_select  = SEL_HALT;
                next_state = ST_RUN;
            end
        endcase

        // Reset is asynchronous, so the mux must see HALT while it is held.
        if (!reset) begin
            pc_select     = SEL_HALT;
            flush         = 1'b0;
            next_state    = ST_RUN;
            do_push       = 1'b0;
            do_pop        = 1'b0;
            set_overflow  = 1'b0;
            set_underflow = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
        end else begin
            state <= next_state;
        end
    end

    // Popped entries are left in place; only the depth moves, so stack_top tracks depth.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            depth <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (do_push) begin
            entries[depth[AW-1:0]] <= pc_1;
            depth                  <= depth + DW'(1);
        end else if (do_pop) begin
            depth <= depth - DW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else begin
            if (set_overflow) begin
                stack_overflow <= 1'b1;
            end
            if (set_underflow) begin
                stack_underflow <= 1'b1;
            end
        end
    end

endmodule
